// File: rtl/vilya_pkg.sv
// Shared opcode encodings, instruction field positions and register index type
// for the vilya register-file ALU core.
package vilya_pkg;

  localparam logic [2:0] OP_LDI = 3'd0;
  localparam logic [2:0] OP_MOV = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_RLC = 3'd6;
  localparam logic [2:0] OP_SEL = 3'd7;

  // ui_in layout: [7]=valid, [6:4]=op, [3:2]=rd, [1:0]=rs
  localparam int INSN_VLD_BIT = 7;
  localparam int OP_MSB       = 6;
  localparam int OP_LSB       = 4;
  localparam int RD_MSB       = 3;
  localparam int RD_LSB       = 2;
  localparam int RS_MSB       = 1;
  localparam int RS_LSB       = 0;

  typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/vilya_alu.sv
// Combinational datapath: result, next flags and register write enable per opcode.
// Latency: zero (pure combinational). Backpressure: none, no handshake.
module vilya_alu
  import vilya_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  input  logic       c_in,
  input  logic       z_in,
  output logic [7:0] result,
  output logic       c_out,
  output logic       z_out,
  output logic       wr_en
);

  logic [8:0] sum;

  assign sum = {1'b0, a} + {1'b0, b};

  // Flags pass through unchanged unless an op explicitly updates them.
  always_comb begin
    result = 8'h00;
    c_out  = c_in;
    z_out  = z_in;
    wr_en  = 1'b0;
    case (op)
      OP_LDI: begin
        result = imm;
        wr_en  = 1'b1;
      end
      OP_MOV: begin
        result = b;
        wr_en  = 1'b1;
      end
      OP_ADD: begin
        result = sum[7:0];
        c_out  = sum[8];
        z_out  = (sum[7:0] == 8'h00);
        wr_en  = 1'b1;
      end
      OP_SUB: begin
        result = a - b;
        c_out  = (a < b);
        z_out  = (a == b);
        wr_en  = 1'b1;
      end
      OP_AND: begin
        result = a & b;
        z_out  = ((a & b) == 8'h00);
        wr_en  = 1'b1;
      end
      OP_XOR: begin
        result = a ^ b;
        z_out  = ((a ^ b) == 8'h00);
        wr_en  = 1'b1;
      end
      OP_RLC: begin
        result = {a[6:0], c_in};
        c_out  = a[7];
        z_out  = ({a[6:0], c_in} == 8'h00);
        wr_en  = 1'b1;
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/emersonmde_vilya.sv
// Four-register 8-bit ALU core in the TinyTapeout wrapper; VILYA_STATUS_EN drives C/Z on uio[7:6].
// Latency: one clock from valid instruction to uo_out. Backpressure: none, host holds inputs stable.
module emersonmde_vilya
  import vilya_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [7:0] regs [4];
  logic       c_flg;
  logic       z_flg;
  reg_idx_t   out_sel;

  logic [2:0] op;
  reg_idx_t   rd;
  reg_idx_t   rs;
  logic       exec;
  logic [7:0] imm;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_z;
  logic       alu_wr;

  assign op   = ui_in[OP_MSB:OP_LSB];
  assign rd   = ui_in[RD_MSB:RD_LSB];
  assign rs   = ui_in[RS_MSB:RS_LSB];
  assign exec = ena & ui_in[INSN_VLD_BIT];

`ifdef VILYA_STATUS_EN
  // uio[7:6] are driven outputs, so only the low six immediate bits are real inputs.
  logic unused_uio;
  assign unused_uio = ^uio_in[7:6];
  assign imm        = {2'b00, uio_in[5:0]};
  assign uio_oe     = 8'hC0;
  assign uio_out    = {c_flg, z_flg, 6'b000000};
`else
  assign imm     = uio_in;
  assign uio_oe  = 8'h00;
  assign uio_out = 8'h00;
`endif

  vilya_alu u_alu (
    .op     (op),
    .a      (regs[rd]),
    .b      (regs[rs]),
    .imm    (imm),
    .c_in   (c_flg),
    .z_in   (z_flg),
    .result (alu_res),
    .c_out  (alu_c),
    .z_out  (alu_z),
    .wr_en  (alu_wr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
      c_flg   <= 1'b0;
      z_flg   <= 1'b0;
      out_sel <= 2'd0;
    end else if (exec) begin
      if (alu_wr) begin
        regs[rd] <= alu_res;
      end
      c_flg <= alu_c;
      z_flg <= alu_z;
      if (op == OP_SEL) begin
        out_sel <= rd;
      end
    end
  end

  assign uo_out = regs[out_sel];

endmodule

// File: tb/tb_emersonmde_vilya.sv
// Directed self-checking bench for emersonmde_vilya (default build and VILYA_STATUS_EN build).
module tb_emersonmde_vilya;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp = 0;
  int n_err = 0;

`ifdef VILYA_STATUS_EN
  localparam logic [7:0] IMM_MASK = 8'h3F;
  localparam logic [7:0] OE_EXP   = 8'hC0;
`else
  localparam logic [7:0] IMM_MASK = 8'hFF;
  localparam logic [7:0] OE_EXP   = 8'h00;
`endif

  localparam logic [2:0] LDI = 3'd0, MOV = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND = 3'd4, XOR = 3'd5, RLC = 3'd6, SEL = 3'd7;

  emersonmde_vilya dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction between edges, let it execute, sample #1 after the edge.
  task automatic issue(input logic vld, input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm);
    @(negedge clk);
    ui_in  = {vld, op, rd, rs};
    uio_in = imm;
    @(posedge clk);
    #1;
    ui_in = 8'h00;
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uo", uo_out, 8'h00);
    check("reset_oe", uio_oe, OE_EXP);
    check("reset_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Mid-sequence asynchronous reset with R0 holding data
    issue(1'b1, LDI, 2'd0, 2'd0, 8'h5A);
    check("ldi_r0_5a", uo_out, 8'h5A & IMM_MASK);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_uo", uo_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_uo", uo_out, 8'h00);
    check("post_reset_c", {7'd0, dut.c_flg}, 8'h00);
    check("post_reset_z", {7'd0, dut.z_flg}, 8'h00);

    // Load R1, then select it
    issue(1'b1, LDI, 2'd1, 2'd0, 8'h3C);
    check("ldi_r1_unselected", uo_out, 8'h00);
    issue(1'b1, SEL, 2'd1, 2'd0, 8'h00);
    check("sel_r1", uo_out, 8'h3C);

    // ena=0 blocks execution
    issue(1'b1, SEL, 2'd2, 2'd0, 8'h00);
    ena = 1'b0;
    issue(1'b1, LDI, 2'd2, 2'd0, 8'h17);
    ena = 1'b1;
    check("ena0_ldi_blocked", uo_out, 8'h00);

`ifndef VILYA_STATUS_EN
    // ADD with carry out, then SUB Rn,Rn
    issue(1'b1, SEL, 2'd0, 2'd0, 8'h00);
    issue(1'b1, LDI, 2'd0, 2'd0, 8'hF0);
    check("ldi_r0_f0", uo_out, 8'hF0);
    issue(1'b1, LDI, 2'd1, 2'd0, 8'h20);
    issue(1'b1, ADD, 2'd0, 2'd1, 8'h00);
    check("add_res", uo_out, 8'h10);
    check("add_c", {7'd0, dut.c_flg}, 8'h01);
    check("add_z", {7'd0, dut.z_flg}, 8'h00);
    issue(1'b1, SUB, 2'd0, 2'd0, 8'h00);
    check("sub_self_res", uo_out, 8'h00);
    check("sub_self_c", {7'd0, dut.c_flg}, 8'h00);
    check("sub_self_z", {7'd0, dut.z_flg}, 8'h01);

    // SUB with borrow, then AND keeps C
    issue(1'b1, SEL, 2'd2, 2'd0, 8'h00);
    issue(1'b1, LDI, 2'd2, 2'd0, 8'h10);
    issue(1'b1, LDI, 2'd3, 2'd0, 8'h20);
    issue(1'b1, SUB, 2'd2, 2'd3, 8'h00);
    check("sub_borrow_res", uo_out, 8'hF0);
    check("sub_borrow_c", {7'd0, dut.c_flg}, 8'h01);
    check("sub_borrow_z", {7'd0, dut.z_flg}, 8'h00);
    issue(1'b1, AND, 2'd2, 2'd3, 8'h00);
    check("and_res", uo_out, 8'h20);
    check("and_z", {7'd0, dut.z_flg}, 8'h00);
    check("and_c_kept", {7'd0, dut.c_flg}, 8'h01);

    // Rotate through carry (C=1 going in)
    issue(1'b1, LDI, 2'd2, 2'd0, 8'h81);
    issue(1'b1, RLC, 2'd2, 2'd1, 8'h00);
    check("rlc1_res", uo_out, 8'h03);
    check("rlc1_c", {7'd0, dut.c_flg}, 8'h01);
    issue(1'b1, RLC, 2'd2, 2'd3, 8'h00);
    check("rlc2_res", uo_out, 8'h07);
    check("rlc2_c", {7'd0, dut.c_flg}, 8'h00);

    // valid=0 is a NOP
    issue(1'b0, RLC, 2'd2, 2'd2, 8'h00);
    check("nop_res", uo_out, 8'h07);
    check("nop_c", {7'd0, dut.c_flg}, 8'h00);

    // XOR Rn,Rn sets Z; MOV leaves flags alone
    issue(1'b1, XOR, 2'd2, 2'd2, 8'h00);
    check("xor_self_res", uo_out, 8'h00);
    check("xor_self_z", {7'd0, dut.z_flg}, 8'h01);
    issue(1'b1, MOV, 2'd2, 2'd3, 8'h00);
    check("mov_res", uo_out, 8'h20);
    check("mov_z_kept", {7'd0, dut.z_flg}, 8'h01);
`else
    // Immediate is limited to six bits; flags on uio[7:6]
    issue(1'b1, SEL, 2'd0, 2'd0, 8'h00);
    issue(1'b1, LDI, 2'd0, 2'd0, 8'hFF);
    check("ldi_masked", uo_out, 8'h3F);
    issue(1'b1, LDI, 2'd0, 2'd0, 8'h20);
    issue(1'b1, ADD, 2'd0, 2'd0, 8'h00);
    issue(1'b1, ADD, 2'd0, 2'd0, 8'h00);
    check("build_80", uo_out, 8'h80);
    issue(1'b1, MOV, 2'd1, 2'd0, 8'h00);
    issue(1'b1, ADD, 2'd0, 2'd1, 8'h00);
    check("add_80_80_res", uo_out, 8'h00);
    check("status_out", uio_out, 8'hC0);
    check("status_oe", uio_oe, 8'hC0);
`endif

    // First valid instruction right after a reset executes
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, LDI, 2'd0, 2'd0, 8'h11);
    check("first_after_reset", uo_out, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
